nw_score_store: RTL and testbench
=================================

NW_SCORE_STORE -- requirements
Module: nw_score_store

Interface
REQ-001 SHALL have parameter N, default 5: sequence length; matrix holds (N+1)x(N+1) cells.
REQ-002 SHALL have parameter W, default 9: signed score width, two's complement.
REQ-003 SHALL have parameter GAP, default -2: signed gap penalty used for boundary initialisation.
REQ-004 SHALL have local widths IW = $clog2(N)+1 for indices and AW = $clog2((N+1)*(N+1)) for addresses.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start_init  input  1  request for automatic boundary initialisation.
REQ-008 en_ins  input  1  request to write ins_val into cell (i+1, j+1).
REQ-009 en_read  input  1  request to fetch the diag, up and left neighbours of cell (i+1, j+1).
REQ-010 i, j  input  IW each  zero-based DP indices, valid range 0..N-1.
REQ-011 ins_val  input  W  signed score to store.
REQ-012 diag, up, left  output  W each  fetched neighbour scores.
REQ-013 rd_valid  output  1  one-cycle pulse: diag, up and left are valid.
REQ-014 init_done  output  1  one-cycle pulse: initialisation finished.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 err  output  1  one-cycle pulse: request rejected because an index was out of range.

Function
REQ-017 SHALL store cell (r,c) at address r*(N+1)+c in an internal single-port RAM (AW-bit address) with one write or one read per cycle and 1-cycle synchronous read latency.
REQ-018 SHALL implement the FSM states IDLE, INIT, RD_DIAG, RD_UP, RD_LEFT and DONE.
REQ-019 SHALL accept requests only in IDLE, with priority start_init > en_ins > en_read; lower-priority requests in the same cycle are dropped, and any request while busy=1 is ignored.
REQ-020 INIT SHALL write cell (0,0)=0, then (0,k)=k*GAP and (k,0)=k*GAP for k=1..N, one write per cycle (2N+1 writes), produced by a running accumulator (prev + GAP) truncated to W bits.
REQ-021 SHALL pulse init_done in the cycle after the last INIT write and return to IDLE in that same cycle.
REQ-022 An accepted en_ins SHALL complete a single-cycle write of ins_val to (i+1, j+1) without leaving IDLE, keeping busy low.
REQ-023 An accepted en_read SHALL latch i and j, then read diag=(i,j), up=(i,j+1) and left=(i+1,j) on consecutive cycles in states RD_DIAG, RD_UP, RD_LEFT, capturing each value one cycle after its address is issued.
REQ-024 rd_valid SHALL pulse exactly 4 cycles after the accepting edge (in DONE); diag, up and left SHALL hold until the next accepted read.
REQ-025 Any en_ins or en_read with i>=N or j>=N SHALL perform no RAM access, cause no state change, and pulse err for one cycle.
REQ-026 Changes to i and j after acceptance SHALL NOT affect an in-progress read.
REQ-027 An en_ins in the cycle that rd_valid pulses SHALL be ignored; it is accepted only in the next IDLE cycle.

Reset
REQ-028 On rst=1 the FSM SHALL go to IDLE, and diag, up, left, rd_valid, init_done, busy and err SHALL be 0 from the next edge.
REQ-029 Reset mid-INIT or mid-read SHALL abort the operation with no completion pulse, and RAM contents SHALL NOT be cleared.

Verification (N=5, W=9, GAP=-2)
REQ-030 Pulse start_init -> busy high for 11 cycles, init_done pulses once, busy then low; a read at i=0,j=0 -> diag=0, up=-2, left=-2.
REQ-031 After init, en_ins at i=0,j=0 with ins_val=5, then read i=0,j=1 -> diag=-2, up=-4, left=5, and rd_valid arrives exactly 4 cycles after acceptance.
REQ-032 Insert 13 at (1,0), 8 at (0,1) and 14 at (1,1), then read i=1,j=1 -> diag=5, up=8, left=13.
REQ-033 en_read with i=5 -> err pulses, no rd_valid, busy stays 0; en_ins with j=7 -> err pulses and the RAM is unchanged.
REQ-034 start_init and en_ins asserted in the same cycle -> INIT runs and the insert is dropped; en_read asserted while busy -> ignored.
REQ-035 rst asserted during RD_UP -> no rd_valid and all outputs 0; a subsequent read returns the previously written values.

Source files
------------

// File: rtl/nw_score_store.sv
// rtl/nw_score_store.sv - Needleman-Wunsch score matrix store with boundary init and neighbour fetch
`timescale 1ns/1ps
module nw_score_store #(
    parameter int N   = 5,
    parameter int W   = 9,
    parameter int GAP = -2,
    localparam int IW = $clog2(N) + 1,
    localparam int AW = $clog2((N + 1) * (N + 1))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_init,
    input  logic          en_ins,
    input  logic          en_read,
    input  logic [IW-1:0] i,
    input  logic [IW-1:0] j,
    input  logic [W-1:0]  ins_val,
    output logic [W-1:0]  diag,
    output logic [W-1:0]  up,
    output logic [W-1:0]  left,
    output logic          rd_valid,
    output logic          init_done,
    output logic          busy,
    output logic          err
);
    localparam int DEPTH = (N + 1) * (N + 1);
    localparam logic [W-1:0] GAP_W = W'(GAP);
    localparam logic [IW:0] LAST_INIT = (IW + 1)'(2 * N);

    typedef enum logic [2:0] {IDLE, INIT, RD_DIAG, RD_UP, RD_LEFT, DONE} state_t;
    state_t state;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  ram_rdata;
    logic [W-1:0]  ram_wdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          ram_re;

    logic [IW:0]   init_cnt;
    logic [IW-1:0] init_k;
    logic [W-1:0]  acc;
    logic [IW-1:0] ri;
    logic [IW-1:0] rj;
    logic          in_range;
    logic          ins_req;

    function automatic logic [AW-1:0] cell_addr(input int r, input int c);
        return AW'(r * (N + 1) + c);
    endfunction

    assign in_range = (int'(i) < N) && (int'(j) < N);
    // An insert arriving while the read result is presented is held off to the next IDLE cycle.
    assign ins_req  = en_ins && !rd_valid;

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!start_init && ins_req && in_range) begin
                        ram_we    = 1'b1;
                        ram_addr  = cell_addr(int'(i) + 1, int'(j) + 1);
                        ram_wdata = ins_val;
                    end
                end
                INIT: begin
                    ram_we    = 1'b1;
                    ram_wdata = acc;
                    if (init_cnt == '0)
                        ram_addr = '0;
                    else if (init_cnt[0])
                        ram_addr = cell_addr(0, int'(init_k));
                    else
                        ram_addr = cell_addr(int'(init_k), 0);
                end
                RD_DIAG: begin
                    ram_re   = 1'b1;
                    ram_addr = cell_addr(int'(ri), int'(rj));
                end
                RD_UP: begin
                    ram_re   = 1'b1;
                    ram_addr = cell_addr(int'(ri), int'(rj) + 1);
                end
                RD_LEFT: begin
                    ram_re   = 1'b1;
                    ram_addr = cell_addr(int'(ri) + 1, int'(rj));
                end
                default: ;
            endcase
        end
    end

    // Matrix storage is deliberately left out of reset so an abort keeps prior scores.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        else if (ram_re)
            ram_rdata <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            diag      <= '0;
            up        <= '0;
            left      <= '0;
            rd_valid  <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            init_cnt  <= '0;
            init_k    <= '0;
            acc       <= '0;
            ri        <= '0;
            rj        <= '0;
        end else begin
            rd_valid  <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_init) begin
                        state    <= INIT;
                        busy     <= 1'b1;
                        init_cnt <= '0;
                        init_k   <= (IW)'(1);
                        acc      <= '0;
                    end else if (ins_req) begin
                        if (!in_range)
                            err <= 1'b1;
                    end else if (en_read) begin
                        if (in_range) begin
                            ri    <= i;
                            rj    <= j;
                            state <= RD_DIAG;
                            busy  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    // Row and column cells for the same k share one accumulator value.
                    if (init_cnt == '0) begin
                        acc <= acc + GAP_W;
                    end else if (!init_cnt[0]) begin
                        acc    <= acc + GAP_W;
                        init_k <= init_k + (IW)'(1);
                    end
                    init_cnt <= init_cnt + (IW + 1)'(1);
                    if (init_cnt == LAST_INIT) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                RD_DIAG: state <= RD_UP;
                RD_UP: begin
                    diag  <= ram_rdata;
                    state <= RD_LEFT;
                end
                RD_LEFT: begin
                    up    <= ram_rdata;
                    state <= DONE;
                end
                DONE: begin
                    left     <= ram_rdata;
                    rd_valid <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nw_score_store.sv
// tb/tb_nw_score_store.sv - scoreboard bench for nw_score_store
`timescale 1ns/1ps
module tb_nw_score_store;
    localparam int N  = 5;
    localparam int W  = 9;
    localparam int IW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_init = 1'b0;
    logic          en_ins = 1'b0;
    logic          en_read = 1'b0;
    logic [IW-1:0] i = '0;
    logic [IW-1:0] j = '0;
    logic [W-1:0]  ins_val = '0;
    logic [W-1:0]  diag, up, left;
    logic          rd_valid, init_done, busy, err;

    int total = 0;
    int bad = 0;
    int rv_count = 0;
    logic [3*W-1:0] sb [$];
    logic [W-1:0] model [0:N][0:N];

    nw_score_store #(.N(N), .W(W), .GAP(-2)) dut (
        .clk(clk), .rst(rst), .start_init(start_init), .en_ins(en_ins),
        .en_read(en_read), .i(i), .j(j), .ins_val(ins_val),
        .diag(diag), .up(up), .left(left), .rd_valid(rd_valid),
        .init_done(init_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            logic [3*W-1:0] exp_v;
            rv_count++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rd_valid got diag=%0d up=%0d left=%0d expected no pulse",
                         $signed(diag), $signed(up), $signed(left));
            end else begin
                exp_v = sb.pop_front();
                if ({diag, up, left} !== exp_v) begin
                    bad++;
                    $display("FAIL read_data got %0d/%0d/%0d expected %0d/%0d/%0d",
                             $signed(diag), $signed(up), $signed(left),
                             $signed(exp_v[3*W-1:2*W]), $signed(exp_v[2*W-1:W]), $signed(exp_v[W-1:0]));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int ii, input int jj, input bit hold);
        int n;
        sb.push_back({model[ii][jj], model[ii][jj+1], model[ii+1][jj]});
        en_read = 1'b1;
        i = IW'(ii);
        j = IW'(jj);
        cyc();
        en_read = 1'b0;
        i = IW'($urandom_range(0, 15));
        j = IW'($urandom_range(0, 15));
        n = 0;
        do begin
            cyc();
            n++;
        end while (!rd_valid && n < 10);
        total++;
        if (n != 4 || !rd_valid) begin
            bad++;
            $display("FAIL rd_latency read(%0d,%0d) got %0d cycles expected 4", ii, jj, n);
        end
        if (!hold) cyc();
    endtask

    task automatic do_ins(input int ii, input int jj, input int val);
        en_ins = 1'b1;
        i = IW'(ii);
        j = IW'(jj);
        ins_val = W'(val);
        cyc();
        en_ins = 1'b0;
        if (ii < N && jj < N) model[ii+1][jj+1] = W'(val);
    endtask

    task automatic model_init();
        model[0][0] = '0;
        for (int k = 1; k <= N; k++) begin
            model[0][k] = W'(-2 * k);
            model[k][0] = W'(-2 * k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        total++;
        if ({diag, up, left, rd_valid, init_done, busy, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got %h expected 0", {diag, up, left, rd_valid, init_done, busy, err});
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_init();
        int busy_n = 0;
        int done_n = 0;
        start_init = 1'b1;
        cyc();
        start_init = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (busy) busy_n++;
            if (init_done) done_n++;
            cyc();
        end
        model_init();
        total++;
        if (busy_n != 11) begin
            bad++;
            $display("FAIL init_busy_cycles got %0d expected 11", busy_n);
        end
        total++;
        if (done_n != 1) begin
            bad++;
            $display("FAIL init_done_pulses got %0d expected 1", done_n);
        end
        do_read(0, 0, 1'b0);
    endtask

    task automatic test_ins_read();
        do_ins(0, 0, 5);
        total++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ins_flags got err=%b busy=%b expected 0 0", err, busy);
        end
        do_read(0, 1, 1'b0);
    endtask

    task automatic test_multi();
        do_ins(1, 0, 13);
        do_ins(0, 1, 8);
        do_ins(1, 1, 14);
        do_ins(2, 0, -7);
        do_ins(3, 3, 100);
        do_ins(3, 4, -100);
        do_ins(4, 3, 255);
        do_read(1, 1, 1'b0);
        do_read(2, 1, 1'b0);
        do_read(4, 4, 1'b0);
    endtask

    task automatic test_err();
        int rv0 = rv_count;
        en_read = 1'b1;
        i = IW'(5);
        j = IW'(0);
        cyc();
        en_read = 1'b0;
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL read_range_err got err=%b busy=%b expected 1 0", err, busy);
        end
        cyc();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_width got err=%b expected 0", err);
        end
        repeat (6) cyc();
        total++;
        if (rv_count != rv0) begin
            bad++;
            $display("FAIL read_range_no_valid got %0d pulses expected 0", rv_count - rv0);
        end
        do_ins(0, 7, 111);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL ins_range_err got err=%b expected 1", err);
        end
        cyc();
        do_read(2, 1, 1'b0);
    endtask

    task automatic test_priority();
        int rv0 = rv_count;
        int done_n = 0;
        int n = 0;
        start_init = 1'b1;
        en_ins = 1'b1;
        i = '0;
        j = '0;
        ins_val = W'(99);
        cyc();
        start_init = 1'b0;
        en_ins = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL prio_init_busy got busy=%b expected 1", busy);
        end
        en_read = 1'b1;
        while (busy && n < 20) begin
            if (n == 3) en_read = 1'b0;
            cyc();
            n++;
            if (init_done) done_n++;
        end
        en_read = 1'b0;
        total++;
        if (busy !== 1'b0 || done_n != 1) begin
            bad++;
            $display("FAIL prio_init_done got busy=%b pulses=%0d expected 0 1", busy, done_n);
        end
        repeat (6) cyc();
        total++;
        if (rv_count != rv0) begin
            bad++;
            $display("FAIL busy_read_ignored got %0d pulses expected 0", rv_count - rv0);
        end
        model_init();
        do_read(1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_read(0, 1, 1'b1);
        en_ins = 1'b1;
        i = '0;
        j = '0;
        ins_val = W'(33);
        cyc();
        en_ins = 1'b0;
        do_read(0, 1, 1'b0);
        do_ins(0, 0, 33);
        do_read(0, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int rv0;
        en_read = 1'b1;
        i = IW'(4);
        j = IW'(4);
        cyc();
        en_read = 1'b0;
        cyc();
        rst = 1'b1;
        rv0 = rv_count;
        cyc();
        total++;
        if ({diag, up, left, rd_valid, init_done, busy, err} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got %h expected 0", {diag, up, left, rd_valid, init_done, busy, err});
        end
        rst = 1'b0;
        repeat (6) cyc();
        total++;
        if (rv_count != rv0) begin
            bad++;
            $display("FAIL reset_mid_no_valid got %0d pulses expected 0", rv_count - rv0);
        end
        do_read(4, 4, 1'b0);
        do_read(2, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_init();
        test_ins_read();
        test_multi();
        test_err();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        repeat (3) cyc();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
